// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Single-outstanding instruction fetch unit. Issues one request pulse per
//   fetch, waits for the memory to return a word, and holds that word for the
//   decoder until it is acknowledged. The acknowledgement either advances pc by
//   one word or redirects it to a branch target. A request that goes
//   unanswered for TIMEOUT cycles is reissued to the same address.
//
// Parameters
//   RESET_PC : first fetch address after reset (bits [1:0] forced to 0)
//   TIMEOUT  : WAIT cycles without imem_valid before the request is reissued
//              (legal range 2..255)
//
// Ports
//   clk                 in   clock, all state changes on its rising edge
//   rst                 in   synchronous active-high reset
//   imem_addr           out  fetch address; always equals pc, word aligned
//   imem_req            out  one-cycle request pulse (high only in REQ)
//   imem_data           in   instruction word from memory
//   imem_valid          in   imem_data valid (looked at only in WAIT)
//   instruction         out  instruction word held for the decoder
//   instruction_RDY_BSY out  1 = instruction valid, 0 = busy
//   decode_ack          in   decoder consumed the instruction (used in HOLD)
//   branch_taken        in   redirect, qualified by decode_ack
//   branch_target       in   redirect address
//   fetch_timeout       out  one-cycle pulse when a request times out
//   instr_counter       out  instructions delivered (acked), wraps at 2^32
//   cycle_counter       out  cycles since reset release, wraps at 2^32
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_data,
  input  logic        imem_valid,
  output logic [31:0] instruction,
  output logic        instruction_RDY_BSY,
  input  logic        decode_ack,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fetch_timeout,
  output logic [31:0] instr_counter,
  output logic [31:0] cycle_counter
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [31:0] PC_INIT   = RESET_PC & 32'hFFFF_FFFC;
  // Timeout fires on the TIMEOUT-th consecutive empty WAIT cycle, i.e. when
  // the count of already-elapsed empty cycles reaches TIMEOUT-1.
  localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [7:0]  wait_cnt;

  // pc is itself a register, so the address output stays registered and is
  // equal to pc in every cycle.
  assign imem_addr = pc;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      pc                  <= PC_INIT;
      wait_cnt            <= 8'd0;
      imem_req            <= 1'b0;
      instruction         <= 32'd0;
      instruction_RDY_BSY <= 1'b0;
      fetch_timeout       <= 1'b0;
      instr_counter       <= 32'd0;
      cycle_counter       <= 32'd0;
    end else begin
      cycle_counter <= cycle_counter + 32'd1;
      // Pulses default low; the transitions into REQ raise imem_req so it is
      // high for exactly the one cycle spent in REQ.
      imem_req      <= 1'b0;
      fetch_timeout <= 1'b0;

      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end

        S_REQ: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (imem_valid) begin
            instruction         <= imem_data;
            instruction_RDY_BSY <= 1'b1;
            wait_cnt            <= 8'd0;
            state               <= S_HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            // Reissue the same address; pc is deliberately left untouched.
            fetch_timeout <= 1'b1;
            imem_req      <= 1'b1;
            wait_cnt      <= 8'd0;
            state         <= S_REQ;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_HOLD: begin
          if (decode_ack) begin
            instruction_RDY_BSY <= 1'b0;
            instr_counter       <= instr_counter + 32'd1;
            // Natural 32-bit overflow gives the required wrap at the top
            // of the address space.
            pc                  <= branch_taken ? (branch_target & 32'hFFFF_FFFC)
                                                : pc + 32'd4;
            imem_req            <= 1'b1;
            state               <= S_REQ;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
